// File: rtl/nabp_filtered_ram_swap_control_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : nabp_filtered_ram_swap_control_pkg
// Brief    : Shared widths and swap-control state encoding for the
//            filtered-line ping-pong buffer.
// Revision : 1.0 - initial release
// ============================================================================
package nabp_filtered_ram_swap_control_pkg;

  // Datapath widths shared with the filter and processing stages
  localparam int kFilteredDataLength = 16;
  localparam int kSLength            = 8;
  localparam int kAngleLength        = 10;

  // Swap-control state encoding
  typedef logic [1:0] swap_state_t;
  localparam logic [1:0] c_ST_FILL = 2'd0;  // filter writing the write bank
  localparam logic [1:0] c_ST_FULL = 2'd1;  // line complete, waiting for a request
  localparam logic [1:0] c_ST_ACK  = 2'd2;  // one-cycle ack after the swap
  localparam logic [1:0] c_ST_DONE = 2'd3;  // final angle delivered, terminal

endpackage : nabp_filtered_ram_swap_control_pkg
`default_nettype wire

// File: rtl/nabp_filtered_ram_swap_control_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : nabp_filtered_ram_swap_control_if
// Brief    : Filter-side write stream and processing-side swap/read bus of
//            the filtered-line ping-pong buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface nabp_filtered_ram_swap_control_if
  import nabp_filtered_ram_swap_control_pkg::*;
#(
  parameter int pDataLength  = kFilteredDataLength,
  parameter int pSLength     = kSLength,
  parameter int pAngleLength = kAngleLength
);

  // Filter stream
  logic                    fl_valid;
  logic                    fl_ready;
  logic [pSLength-1:0]     fl_s_val;
  logic [pDataLength-1:0]  fl_val;
  logic [pAngleLength-1:0] fl_angle;
  logic                    fl_last;
  logic                    fl_end;

  // Processing swap handshake and read ports
  logic                    pr_next_angle;
  logic                    pr_next_angle_ack;
  logic [pAngleLength-1:0] pr_angle;
  logic                    pr_has_next_angle;
  logic [pSLength-1:0]     pr0_s_val;
  logic [pSLength-1:0]     pr1_s_val;
  logic [pDataLength-1:0]  pr0_val;
  logic [pDataLength-1:0]  pr1_val;

  // Debug
  logic                    db_seq_err;

  // Filter + processing side (drives beats, requests and read addresses)
  modport master (
    output fl_valid, fl_s_val, fl_val, fl_angle, fl_last, fl_end,
    output pr_next_angle, pr0_s_val, pr1_s_val,
    input  fl_ready, pr_next_angle_ack, pr_angle, pr_has_next_angle,
    input  pr0_val, pr1_val, db_seq_err
  );

  // Buffer side
  modport slave (
    input  fl_valid, fl_s_val, fl_val, fl_angle, fl_last, fl_end,
    input  pr_next_angle, pr0_s_val, pr1_s_val,
    output fl_ready, pr_next_angle_ack, pr_angle, pr_has_next_angle,
    output pr0_val, pr1_val, db_seq_err
  );

endinterface : nabp_filtered_ram_swap_control_if
`default_nettype wire

// File: rtl/nabp_filtered_line_ram.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : nabp_filtered_line_ram
// Brief    : One projection line of filtered samples: one write port and two
//            independent registered read ports (1-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module nabp_filtered_line_ram
  import nabp_filtered_ram_swap_control_pkg::*;
#(
  parameter int pDataLength = kFilteredDataLength,
  parameter int pSLength    = kSLength
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [pSLength-1:0]    waddr,
  input  logic [pDataLength-1:0] wdata,
  input  logic [pSLength-1:0]    raddr0,
  input  logic [pSLength-1:0]    raddr1,
  output logic [pDataLength-1:0] rdata0,
  output logic [pDataLength-1:0] rdata1
);

  // Storage is deliberately left unreset so it maps onto block RAM
  logic [pDataLength-1:0] r_mem [2**pSLength];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Registered read ports; output registers clear on reset so the buffer
  // presents zero data out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      rdata0 <= r_mem[raddr0];
      rdata1 <= r_mem[raddr1];
    end
  end

endmodule : nabp_filtered_line_ram
`default_nettype wire

// File: rtl/nabp_filtered_ram_swap_control.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : nabp_filtered_ram_swap_control
// Brief    : Ping-pong line buffer between the filter stage and processing.
//            The filter fills the write bank while processing reads the
//            previous line from the read bank; banks swap on an angle
//            request/ack handshake.
// Option   : NABP_FILTERED_RAM_SEQ_CHECK_EN - enables the sticky write
//            sequencing checker on db_seq_err (tied 0 otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module nabp_filtered_ram_swap_control
  import nabp_filtered_ram_swap_control_pkg::*;
#(
  parameter int pDataLength  = kFilteredDataLength,
  parameter int pSLength     = kSLength,
  parameter int pAngleLength = kAngleLength
) (
  input  logic                            clk,
  input  logic                            reset_n,
  nabp_filtered_ram_swap_control_if.slave bus
);

  swap_state_t             r_state;
  logic                    r_wb;        // bank currently written by the filter
  logic                    r_rd_bank;   // read bank as of the read address cycle
  logic [pAngleLength-1:0] r_wr_angle;  // angle of the line in the write bank
  logic                    r_wr_end;
  logic [pAngleLength-1:0] r_pr_angle;  // angle of the line in the read bank
  logic                    r_rd_end;

  logic                    w_fl_ready;
  logic                    w_accept;
  logic [pDataLength-1:0]  w_rd0 [2];
  logic [pDataLength-1:0]  w_rd1 [2];

  assign w_fl_ready = (r_state == c_ST_FILL);
  assign w_accept   = bus.fl_valid && w_fl_ready;

  assign bus.fl_ready          = w_fl_ready;
  assign bus.pr_next_angle_ack = (r_state == c_ST_ACK);
  assign bus.pr_has_next_angle = (r_state != c_ST_DONE);
  assign bus.pr_angle          = r_pr_angle;

  // Swap FSM: fill a line, wait for a request, swap banks and ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= c_ST_FILL;
      r_wb       <= 1'b0;
      r_wr_angle <= '0;
      r_wr_end   <= 1'b0;
      r_pr_angle <= '0;
      r_rd_end   <= 1'b0;
    end else begin
      case (r_state)
        c_ST_FILL: begin
          if (w_accept && bus.fl_last) begin
            r_wr_angle <= bus.fl_angle;
            r_wr_end   <= bus.fl_end;
            r_state    <= c_ST_FULL;
          end
        end
        c_ST_FULL: begin
          // fl_ready is low here, so a swap can never split a write
          if (bus.pr_next_angle) begin
            r_wb       <= ~r_wb;
            r_pr_angle <= r_wr_angle;
            r_rd_end   <= r_wr_end;
            r_state    <= c_ST_ACK;
          end
        end
        c_ST_ACK: begin
          r_state <= r_rd_end ? c_ST_DONE : c_ST_FILL;
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  // Track the read bank alongside the address so read data follows the bank
  // that was selected when the address was presented
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_bank <= 1'b1;
    end else begin
      r_rd_bank <= ~r_wb;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    nabp_filtered_line_ram #(
      .pDataLength (pDataLength),
      .pSLength    (pSLength)
    ) u_line_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (w_accept && (r_wb == 1'(b))),
      .waddr   (bus.fl_s_val),
      .wdata   (bus.fl_val),
      .raddr0  (bus.pr0_s_val),
      .raddr1  (bus.pr1_s_val),
      .rdata0  (w_rd0[b]),
      .rdata1  (w_rd1[b])
    );
  end : g_bank

  assign bus.pr0_val = w_rd0[r_rd_bank];
  assign bus.pr1_val = w_rd1[r_rd_bank];

`ifdef NABP_FILTERED_RAM_SEQ_CHECK_EN
  localparam logic [pSLength-1:0] c_S_LAST = '1;

  logic [pSLength-1:0] r_exp_s;
  logic                r_seq_err;

  // Expect addresses 0,1,2,... per line with fl_last exactly on the final one;
  // a missing fl_last at the final index is the wrap case
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_exp_s   <= '0;
      r_seq_err <= 1'b0;
    end else if (w_accept) begin
      if ((bus.fl_s_val != r_exp_s) || (bus.fl_last != (r_exp_s == c_S_LAST))) begin
        r_seq_err <= 1'b1;
      end
      r_exp_s <= bus.fl_last ? '0 : r_exp_s + pSLength'(1);
    end
  end

  assign bus.db_seq_err = r_seq_err;
`else
  assign bus.db_seq_err = 1'b0;
`endif

endmodule : nabp_filtered_ram_swap_control
`default_nettype wire

// File: tb/tb_nabp_filtered_ram_swap_control.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_nabp_filtered_ram_swap_control
// Brief    : Scoreboard bench for the filtered-line ping-pong buffer.
//            The stimulus side predicts read data and swap angles from a
//            line-level model; a monitor compares whenever data or acks show.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nabp_filtered_ram_swap_control;
  import nabp_filtered_ram_swap_control_pkg::*;

  localparam int DW = kFilteredDataLength;
  localparam int SW = kSLength;
  localparam int AW = kAngleLength;
  localparam int NS = 1 << SW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nabp_filtered_ram_swap_control_if #(.pDataLength(DW), .pSLength(SW), .pAngleLength(AW)) bus ();

  nabp_filtered_ram_swap_control #(
    .pDataLength (DW),
    .pSLength    (SW),
    .pAngleLength(AW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int cyc;
    int e0;
    int e1;
  } rd_t;

  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  rd_t rd_q[$];
  int  ang_q[$];
  int  cur[NS];        // line visible through the read bank
  int  pend[NS];       // line being written
  bit  cur_valid = 0;
  bit  reads_on = 0;
  bit  awaiting = 0;
  int  req_cyc = 0;
  int  last_cyc = -100;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_read(input int a0, input int a1);
    bus.pr0_s_val = SW'(a0);
    bus.pr1_s_val = SW'(a1);
    rd_q.push_back('{cyc + 1, cur[a0], cur[a1]});
  endtask

  task automatic drive_reads();
    int a0, a1;
    if (reads_on && cur_valid) begin
      a0 = int'($urandom_range(0, NS - 1));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : int'($urandom_range(0, NS - 1));
      push_read(a0, a1);
    end
  endtask

  // One clock; when an ack shows up the model switches lines before this
  // cycle's read addresses are issued (ack-cycle reads see the new line)
  task automatic tick();
    int exp_ack;
    step();
    if (awaiting && bus.pr_next_angle_ack) begin
      exp_ack = (last_cyc + 2 > req_cyc + 1) ? last_cyc + 2 : req_cyc + 1;
      chk("ack_cycle", cyc, exp_ack);
      cur       = pend;
      cur_valid = 1;
      awaiting  = 0;
      bus.pr_next_angle = 1'b0;
    end
    drive_reads();
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 40 && awaiting; i++) tick();
    chk("ack_timeout", awaiting, 0);
    awaiting = 0;
    bus.pr_next_angle = 1'b0;
  endtask

  task automatic request_swap();
    bus.pr_next_angle = 1'b1;
    req_cyc  = cyc;
    awaiting = 1;
    wait_ack();
  endtask

  task automatic post_ack(input bit is_end);
    tick();
    chk("ack_single_pulse", bus.pr_next_angle_ack, 0);
    chk("has_next_after_ack", bus.pr_has_next_angle, !is_end);
    chk("fl_ready_after_ack", bus.fl_ready, !is_end);
  endtask

  // Writes pend[] as one line in address order with random idle gaps
  task automatic write_line(input int angle, input bit is_end, input int req_at);
    for (int s = 0; s < NS; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.fl_valid = 1'b0;
        tick();
      end
      bus.fl_valid = 1'b1;
      bus.fl_s_val = SW'(s);
      bus.fl_val   = DW'(pend[s]);
      bus.fl_last  = (s == NS - 1);
      bus.fl_angle = (s == NS - 1) ? AW'(angle) : AW'($urandom);
      bus.fl_end   = (s == NS - 1) ? is_end : 1'($urandom);
      if (s == req_at) begin
        bus.pr_next_angle = 1'b1;
        req_cyc  = cyc;
        awaiting = 1;
      end
      if (s == NS - 1) begin
        last_cyc = cyc;
        ang_q.push_back(angle);
      end
      tick();
    end
    bus.fl_valid = 1'b0;
    bus.fl_last  = 1'b0;
    bus.fl_end   = 1'b0;
    chk("fl_ready_after_last", bus.fl_ready, 0);
    chk("seq_err_clean_line", bus.db_seq_err, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_fl_ready"}, bus.fl_ready, 1);
    chk({tag, "_ack"}, bus.pr_next_angle_ack, 0);
    chk({tag, "_pr_angle"}, bus.pr_angle, 0);
    chk({tag, "_has_next"}, bus.pr_has_next_angle, 1);
    chk({tag, "_pr0_val"}, bus.pr0_val, 0);
    chk({tag, "_pr1_val"}, bus.pr1_val, 0);
    chk({tag, "_seq_err"}, bus.db_seq_err, 0);
  endtask

  // Asserts reset asynchronously mid-cycle and checks outputs at once
  task automatic do_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals(tag);
    bus.fl_valid      = 1'b0;
    bus.fl_last       = 1'b0;
    bus.fl_end        = 1'b0;
    bus.pr_next_angle = 1'b0;
    awaiting  = 0;
    cur_valid = 0;
    last_cyc  = -100;
    ang_q.delete();
    rd_q.delete();
    step();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rd_t r;
    bus.fl_valid = 1'b0;
    bus.fl_s_val = '0;
    bus.fl_val   = '0;
    bus.fl_angle = '0;
    bus.fl_last  = 1'b0;
    bus.fl_end   = 1'b0;
    bus.pr_next_angle = 1'b0;
    bus.pr0_s_val = '0;
    bus.pr1_s_val = '0;

    // Monitor: compares read data and swap angles as the DUT presents them
    fork
      forever begin
        @(negedge clk);
        if (reset_n) begin
          if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
            r = rd_q.pop_front();
            chk("read_slot", r.cyc, cyc);
            chk("pr0_val", bus.pr0_val, r.e0);
            chk("pr1_val", bus.pr1_val, r.e1);
          end
          if (bus.pr_next_angle_ack) begin
            chk("ack_has_line", ang_q.size(), 1);
            if (ang_q.size() > 0) chk("pr_angle", bus.pr_angle, ang_q.pop_front());
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("in_reset");
    step();
    reset_n = 1'b1;
    tick();
    check_reset_vals("after_reset");

    // Basic line: val=s, angle 5, request after 10 idle cycles
    for (int s = 0; s < NS; s++) pend[s] = s;
    write_line(5, 1'b0, -1);
    repeat (10) tick();
    chk("full_fl_ready", bus.fl_ready, 0);
    chk("full_no_ack", bus.pr_next_angle_ack, 0);
    request_swap();
    post_ack(1'b0);
    push_read(17, 200);
    tick();
    push_read(200, 200);
    tick();
    reads_on = 1;
    repeat (20) tick();
    reads_on = 0;

    // Request raised while the line is still being written
    for (int s = 0; s < NS; s++) pend[s] = int'($urandom_range(0, (1 << DW) - 1));
    write_line(3, 1'b0, 200);
    wait_ack();
    post_ack(1'b0);
    reads_on = 1;
    repeat (10) tick();

    // Ping-pong: line A readable while line B is written
    for (int s = 0; s < NS; s++) pend[s] = s;
    reads_on = 0;
    tick();
    write_line(1, 1'b0, -1);
    request_swap();
    post_ack(1'b0);
    for (int s = 0; s < NS; s++) pend[s] = s + 1000;
    reads_on = 1;
    write_line(2, 1'b0, -1);
    repeat (5) tick();
    request_swap();
    post_ack(1'b0);
    repeat (10) tick();
    reads_on = 0;

    // Final angle: no further lines, no further acks
    for (int s = 0; s < NS; s++) pend[s] = int'($urandom_range(0, (1 << DW) - 1));
    tick();
    write_line(9, 1'b1, -1);
    request_swap();
    post_ack(1'b1);
    bus.pr_next_angle = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("done_no_ack", bus.pr_next_angle_ack, 0);
    end
    bus.pr_next_angle = 1'b0;
    chk("done_has_next", bus.pr_has_next_angle, 0);
    reads_on = 1;
    repeat (5) tick();
    reads_on = 0;
    repeat (2) tick();

    // Reset out of DONE, one line, then reset in the middle of the next
    do_reset("reset_from_done");
    for (int s = 0; s < NS; s++) pend[s] = int'($urandom_range(1, (1 << DW) - 1));
    write_line(4, 1'b0, -1);
    request_swap();
    post_ack(1'b0);
    push_read(10, 20);
    tick();
    tick();
    for (int s = 0; s <= 100; s++) begin
      bus.fl_valid = 1'b1;
      bus.fl_s_val = SW'(s);
      bus.fl_val   = DW'($urandom);
      bus.fl_last  = 1'b0;
      if (s < 100) tick();
    end
    do_reset("reset_mid_line");
    for (int s = 0; s < NS; s++) pend[s] = int'($urandom_range(0, (1 << DW) - 1));
    write_line(7, 1'b0, -1);
    request_swap();
    post_ack(1'b0);
    reads_on = 1;
    repeat (15) tick();
    reads_on = 0;
    repeat (2) tick();

    // Out-of-order write addresses 0,1,3
    do_reset("reset_before_seq");
    for (int i = 0; i < 3; i++) begin
      bus.fl_valid = 1'b1;
      bus.fl_s_val = SW'((i == 2) ? 3 : i);
      bus.fl_val   = DW'(i);
      bus.fl_last  = 1'b0;
      tick();
    end
    bus.fl_valid = 1'b0;
    tick();
`ifdef NABP_FILTERED_RAM_SEQ_CHECK_EN
    chk("seq_err_set", bus.db_seq_err, 1);
    repeat (3) tick();
    chk("seq_err_sticky", bus.db_seq_err, 1);
    do_reset("seq_err_cleared");
`else
    chk("seq_err_disabled", bus.db_seq_err, 0);
    repeat (3) tick();
    chk("seq_err_disabled_hold", bus.db_seq_err, 0);
`endif
    repeat (2) tick();
    chk("read_queue_drained", rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_nabp_filtered_ram_swap_control
`default_nettype wire

// File: doc/nabp_filtered_ram_swap_control.md
Name: nabp_filtered_ram_swap_control

Overview:
- Ping-pong buffer between the filter stage and the processing swap control.
- The filter writes one filtered projection line (one angle, all s samples) into the write bank while processing reads the previous line from the read bank through two independent read ports.
- Banks swap through an angle request/ack handshake.
- Drives the processing stage's angle, has-next-angle, ack and both data inputs.

Parameters:
- pDataLength, 16, filtered sample width (equals kFilteredDataLength)
- pSLength, 8, s address width; line holds 2^pSLength samples
- pAngleLength, 10, angle width (equals kAngleLength)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- fl_valid  in  1  filter beat valid
- fl_ready  out  1  block accepts beat
- fl_s_val  in  pSLength  sample address of beat
- fl_val  in  pDataLength  filtered sample
- fl_angle  in  pAngleLength  line angle, sampled on fl_last beat
- fl_last  in  1  final beat of line
- fl_end  in  1  sampled on fl_last beat: this line is the final angle
- pr_next_angle  in  1  processing requests next line (level, held until ack)
- pr_next_angle_ack  out  1  one-cycle ack; new line readable from next cycle
- pr_angle  out  pAngleLength  angle of read bank line
- pr_has_next_angle  out  1  further lines will be supplied
- pr0_s_val, pr1_s_val  in  pSLength  read addresses
- pr0_val, pr1_val  out  pDataLength  read data, 1-cycle latency
- db_seq_err  out  1  sticky sequencing error (see Optional Feature)

Behaviour:
- Reset values: fl_ready=1, pr_next_angle_ack=0, pr_angle=0, pr_has_next_angle=1, pr0_val=pr1_val=0, db_seq_err=0, wb=0, state FILL. RAM contents are not reset.
- Beat accepted when fl_valid&&fl_ready. Writes fl_val to bank wb at fl_s_val.
- On accepted fl_last: latch fl_angle into wr_angle and fl_end into wr_end, then go to FULL. fl_ready drops the next cycle.
- States:
  - FILL: fl_ready=1.
  - FULL: fl_ready=0; waits for a request.
  - ACK: one cycle, asserts pr_next_angle_ack.
  - DONE: terminal.
- FULL && pr_next_angle at clock edge:
  - toggle wb; pr_angle<=wr_angle; rd_end<=wr_end.
  - Next state is ACK.
- ACK → FILL if !rd_end, else DONE.
- pr_next_angle is ignored during ACK. Processing must drop it in the ack cycle.
- In DONE: pr_has_next_angle=0, fl_ready=0, no further acks; remains until reset.
- Read bank is ~wb. pr*_val are registered reads using the read bank as of the address cycle, so reads issued in the ACK cycle return new-line data.
- Swap and write never coincide: swap only occurs in FULL, where fl_ready=0.
- Request before the first line completes: held off, ack after fill completes (2 cycles after the fl_last edge at earliest).
- Reads before the first ack return undefined RAM data.
- Both read ports may share an address; each returns the same word.
- fl_s_val order is free. Unwritten addresses keep stale data.
- Async reset mid-line: line discarded, state returns to reset values.

Optional Feature:
- Macro: NABP_FILTERED_RAM_SEQ_CHECK_EN.
- With the macro: track the expected address, 0 at the start of each line and +1 per accepted beat. Set db_seq_err sticky if fl_s_val≠expected, or if fl_last arrives at an index other than 2^pSLength−1, or if the expected address wraps without fl_last.
- Without the macro: no tracking logic; db_seq_err is tied 0.

Decomposition:
- Shared package/defines:
  - kFilteredDataLength, kSLength, kAngleLength.
  - State encoding: FILL, FULL, ACK, DONE.
- One sub-module, nabp_filtered_line_ram: 2^pSLength×pDataLength, one write port, two registered read ports, instantiated twice.
- Bank select, write-enable steering and output muxing live in the top module.

Test Plan:
- Reset, write s=0..255 with val=s, fl_angle=5, fl_last at 255, pr_next_angle raised after 10 cycles → one ack pulse, pr_angle=5, pr0_s_val=17 gives pr0_val=17 one cycle later, pr1_s_val=200 gives 200.
- Request raised before the line finishes → fl_ready=0 the cycle after fl_last, ack exactly 2 cycles after the fl_last edge, single pulse.
- Ping-pong: line A (angle 1, val=s) read while line B (angle 2, val=s+1000) is written → reads still return A until ack, then pr_angle=2 and reads return B.
- Line with fl_end=1 (angle 9) → ack, then pr_has_next_angle=0 and fl_ready=0; later request gets no ack.
- Async reset asserted mid-line at s=100 → all outputs at reset values immediately; a full new line then swaps normally.
- With NABP_FILTERED_RAM_SEQ_CHECK_EN: write order 0,1,3 → db_seq_err=1 and sticky until reset. Without the macro: db_seq_err stays 0.
